// File: rtl/fetch_arbiter_if.sv
// rtl/fetch_arbiter_if.sv - handshake bundle between core fetchers, fetch_arbiter and instruction memory
//
// Core request channel:  fetch_req_val/fetch_req_addr in, fetch_req_rdy out of the arbiter
// Core response channel: fetch_resp_val/fetch_resp_inst out, fetch_resp_rdy in
// Memory request:        mem2fetch_req_val/mem2fetch_req_addr out, mem2fetch_req_rdy in
// Memory response:       mem2fetch_resp_val/mem2fetch_resp_inst in, mem2fetch_resp_rdy out
// Per-core vectors are packed; core i owns slice [i*WIDTH +: WIDTH].
// slave modport: the arbiter. master modport: the cores plus memory.
interface fetch_arbiter_if #(
  parameter int NUM_CORES      = 4,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 16
);
  logic [NUM_CORES-1:0]                fetch_req_val;
  logic [NUM_CORES*MEM_ADDR_WIDTH-1:0] fetch_req_addr;
  logic [NUM_CORES-1:0]                fetch_req_rdy;
  logic [NUM_CORES-1:0]                fetch_resp_val;
  logic [NUM_CORES*MEM_DATA_WIDTH-1:0] fetch_resp_inst;
  logic [NUM_CORES-1:0]                fetch_resp_rdy;
  logic                                mem2fetch_req_val;
  logic                                mem2fetch_req_rdy;
  logic [MEM_ADDR_WIDTH-1:0]           mem2fetch_req_addr;
  logic                                mem2fetch_resp_val;
  logic                                mem2fetch_resp_rdy;
  logic [MEM_DATA_WIDTH-1:0]           mem2fetch_resp_inst;

  modport slave (
    input  fetch_req_val, fetch_req_addr, fetch_resp_rdy,
           mem2fetch_req_rdy, mem2fetch_resp_val, mem2fetch_resp_inst,
    output fetch_req_rdy, fetch_resp_val, fetch_resp_inst,
           mem2fetch_req_val, mem2fetch_req_addr, mem2fetch_resp_rdy
  );

  modport master (
    output fetch_req_val, fetch_req_addr, fetch_resp_rdy,
           mem2fetch_req_rdy, mem2fetch_resp_val, mem2fetch_resp_inst,
    input  fetch_req_rdy, fetch_resp_val, fetch_resp_inst,
           mem2fetch_req_val, mem2fetch_req_addr, mem2fetch_resp_rdy
  );
endinterface

// File: rtl/fetch_arbiter.sv
// rtl/fetch_arbiter.sv - round-robin arbiter sharing one instruction-memory channel among core fetchers
//
// clk_i       : system clock, all state updates on the rising edge
// reset_i     : synchronous active-high reset
// bus         : fetch_arbiter_if slave modport (core request/response + memory request/response)
// busy_o      : high whenever a transaction is in flight (any state but IDLE)
// grant_idx_o : index of the current or most recently granted core
module fetch_arbiter #(
  parameter int  NUM_CORES      = 4,
  parameter int  MEM_ADDR_WIDTH = 8,
  parameter int  MEM_DATA_WIDTH = 16,
  localparam int IDX_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fetch_arbiter_if.slave    bus,
  output logic              busy_o,
  output logic [IDX_W-1:0]  grant_idx_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  logic [1:0]                state_q,  state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          grant_q,  grant_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [MEM_DATA_WIDTH-1:0] inst_q,   inst_d;

  logic                      hi_found, lo_found, win_found;
  logic [IDX_W-1:0]          hi_idx, lo_idx, win_idx;
  logic [MEM_ADDR_WIDTH-1:0] win_addr;
  logic                      grant_resp_rdy;

  logic [NUM_CORES-1:0]                req_rdy;
  logic [NUM_CORES-1:0]                resp_val;
  logic [NUM_CORES*MEM_DATA_WIDTH-1:0] resp_inst;

  // Circular priority search from rr_ptr: the lowest requester at or above
  // the pointer wins; failing that, the lowest requester overall (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!hi_found && bus.fetch_req_val[i] && (IDX_W'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (!lo_found && bus.fetch_req_val[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_addr       = '0;
    grant_resp_rdy = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = bus.fetch_req_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      end
      // Only the granted core's response-ready matters; the rest are ignored.
      if (grant_q == IDX_W'(i)) begin
        grant_resp_rdy = bus.fetch_resp_rdy[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          addr_d  = win_addr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem2fetch_req_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem2fetch_resp_val) begin
          inst_d  = bus.mem2fetch_resp_inst;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (grant_resp_rdy) begin
          // Pointer moves just past the core that was served, so it drops to
          // lowest priority for the next arbitration.
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
    end
  end

  // Handshake outputs are masked while reset is high so no core or memory
  // sees an accept for a transaction the reset is about to discard.
  always_comb begin
    req_rdy   = '0;
    resp_val  = '0;
    resp_inst = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!reset_i && (state_q == S_IDLE) && win_found && (win_idx == IDX_W'(i))) begin
        req_rdy[i] = 1'b1;
      end
      if (!reset_i && (state_q == S_DELIVER) && (grant_q == IDX_W'(i))) begin
        resp_val[i]                                   = 1'b1;
        resp_inst[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = inst_q;
      end
    end
  end

  assign bus.fetch_req_rdy      = req_rdy;
  assign bus.fetch_resp_val     = resp_val;
  assign bus.fetch_resp_inst    = resp_inst;
  assign bus.mem2fetch_req_val  = !reset_i && (state_q == S_REQ);
  assign bus.mem2fetch_req_addr = addr_q;
  assign bus.mem2fetch_resp_rdy = !reset_i && (state_q == S_WAIT);
  assign busy_o                 = (state_q != S_IDLE);
  assign grant_idx_o            = grant_q;

endmodule
